// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command/display bundle between the push-button front end and the stopwatch
// controller. The controller takes the slave side; whoever issues the button
// pulses and reads the display takes the master side.
interface bcd_stopwatch_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   i_start;
    logic                   i_stop;
    logic                   i_clear;
    logic                   i_lap;
    logic [4*NDIGITS-1:0]   o_bcd_out;
    logic                   o_running;
    logic                   o_tick;
    logic                   o_overflow;

    modport master (
        output i_start, i_stop, i_clear, i_lap,
        input  o_bcd_out, o_running, o_tick, o_overflow
    );

    modport slave (
        input  i_start, i_stop, i_clear, i_lap,
        output o_bcd_out, o_running, o_tick, o_overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: prescaled count tick, start/stop/clear FSM and a
// cascade of NDIGITS decimal digits with sticky wrap flag.
// Optional lap/display-freeze feature is built when LAP_HOLD_EN is defined.
//
// state   | meaning
// S_IDLE  | cleared, prescaler and digits at zero, waiting for start
// S_RUN   | prescaler counting, digits advance on every tick
// S_PAUSE | counting frozen, prescaler phase kept for resume
module bcd_stopwatch_ctrl #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_stopwatch_ctrl_if.slave    bus
);
    localparam int           PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PW-1:0]          r_presc;
    logic [4*NDIGITS-1:0]   r_digits;
    logic [4*NDIGITS-1:0]   w_digits_inc;
    logic                   w_all9;
    logic                   w_tick;
    logic                   r_tick;
    logic                   r_running;
    logic                   r_overflow;

    assign w_tick = (r_state == S_RUN) && (r_presc == PS_MAX);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: clear beats everything, stop beats start only while running
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
                S_RUN:   if (bus.i_stop)  w_state_nxt = S_PAUSE;
                S_PAUSE: if (bus.i_start) w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Decimal ripple: a digit advances only when every lower digit is at 9
    always_comb begin
        logic v_carry;
        w_digits_inc = r_digits;
        v_carry      = 1'b1;
        for (int k = 0; k < NDIGITS; k++) begin
            if (v_carry) begin
                w_digits_inc[4*k +: 4] = (r_digits[4*k +: 4] == 4'd9) ? 4'd0
                                         : r_digits[4*k +: 4] + 4'd1;
            end
            v_carry = v_carry && (r_digits[4*k +: 4] == 4'd9);
        end
        w_all9 = v_carry;
    end

    // Prescaler runs only in RUN and holds its phase through PAUSE
    always_ff @(posedge clk) begin
        if (rst || bus.i_clear)    r_presc <= '0;
        else if (r_state == S_RUN) r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end

    // Digit chain, wrap flag and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits   <= '0;
            r_tick     <= 1'b0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tick    <= w_tick && !bus.i_clear;
            r_running <= (w_state_nxt == S_RUN);
            if (bus.i_clear) begin
                r_digits   <= '0;
                r_overflow <= 1'b0;
            end else if (w_tick) begin
                r_digits <= w_digits_inc;
                if (w_all9) r_overflow <= 1'b1;
            end
        end
    end

    assign bus.o_running  = r_running;
    assign bus.o_tick     = r_tick;
    assign bus.o_overflow = r_overflow;

`ifdef LAP_HOLD_EN
    logic                   r_freeze;
    logic [4*NDIGITS-1:0]   r_hold;

    // Lap toggles the display freeze; entering freeze snapshots the live digits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freeze <= 1'b0;
            r_hold   <= '0;
        end else if (bus.i_clear) begin
            r_freeze <= 1'b0;
        end else if (bus.i_lap && (r_state != S_IDLE)) begin
            r_freeze <= ~r_freeze;
            if (!r_freeze) r_hold <= r_digits;
        end
    end

    assign bus.o_bcd_out = r_freeze ? r_hold : r_digits;
`else
    logic w_lap_unused;
    assign w_lap_unused  = bus.i_lap;
    assign bus.o_bcd_out = r_digits;
`endif
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
module tb_bcd_stopwatch_ctrl;
    localparam int ND = 2;
    localparam int PS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_stopwatch_ctrl_if #(.NDIGITS(ND)) bus ();

    bcd_stopwatch_ctrl #(.NDIGITS(ND), .PRESCALE(PS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic s, input logic p, input logic c, input logic l);
        bus.i_start = s;
        bus.i_stop  = p;
        bus.i_clear = c;
        bus.i_lap   = l;
        cyc(1);
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_lap   = 1'b0;
    endtask

    // advance until the display shows v in a tick cycle, bounded by budget
    task automatic wait_bcd(input logic [7:0] v, input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            cyc(1);
            if (bus.o_tick && bus.o_bcd_out == v) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nt;
        int first;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_lap   = 1'b0;

        // 1: reset and idle
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        chk("rst_bcd", 32'(bus.o_bcd_out), 32'h00);
        chk("rst_running", 32'(bus.o_running), 32'd0);
        chk("rst_tick", 32'(bus.o_tick), 32'd0);
        chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.o_tick) nt++;
        end
        chk("idle_ticks", 32'(nt), 32'd0);
        chk("idle_bcd", 32'(bus.o_bcd_out), 32'h00);

        // 2: start and run 40 cycles
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_running", 32'(bus.o_running), 32'd1);
        nt = 0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (bus.o_tick) begin
                nt++;
                if (first == 0) first = i;
            end
        end
        chk("first_tick_cycle", 32'(first), 32'd4);
        chk("tick_count_40", 32'(nt), 32'd10);
        chk("bcd_after_10", 32'(bus.o_bcd_out), 32'h10);
        chk("run_running", 32'(bus.o_running), 32'd1);

        // 3: wrap from 99 to 00
        wait_bcd(8'h99, 500, "reach_99");
        chk("ovf_before_wrap", 32'(bus.o_overflow), 32'd0);
        cyc(3);
        chk("no_tick_mid", 32'(bus.o_tick), 32'd0);
        cyc(1);
        chk("wrap_bcd", 32'(bus.o_bcd_out), 32'h00);
        chk("wrap_tick", 32'(bus.o_tick), 32'd1);
        chk("wrap_ovf", 32'(bus.o_overflow), 32'd1);
        cyc(8);
        chk("ovf_sticky", 32'(bus.o_overflow), 32'd1);
        chk("bcd_after_wrap", 32'(bus.o_bcd_out), 32'h02);

        // 4: pause keeps prescaler phase
        wait_bcd(8'h05, 100, "reach_05");
        cyc(1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_running", 32'(bus.o_running), 32'd0);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.o_tick) nt++;
        end
        chk("pause_ticks", 32'(nt), 32'd0);
        chk("pause_bcd", 32'(bus.o_bcd_out), 32'h05);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_running", 32'(bus.o_running), 32'd1);
        chk("resume_tick0", 32'(bus.o_tick), 32'd0);
        cyc(1);
        chk("resume_tick1", 32'(bus.o_tick), 32'd0);
        cyc(1);
        chk("resume_tick2", 32'(bus.o_tick), 32'd1);
        chk("resume_bcd", 32'(bus.o_bcd_out), 32'h06);

        // 5: clear+stop+start together while running
        wait_bcd(8'h37, 500, "reach_37");
        chk("ovf_held_37", 32'(bus.o_overflow), 32'd1);
        cmd(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_bcd", 32'(bus.o_bcd_out), 32'h00);
        chk("clr_ovf", 32'(bus.o_overflow), 32'd0);
        chk("clr_running", 32'(bus.o_running), 32'd0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.o_tick) nt++;
        end
        chk("clr_idle_ticks", 32'(nt), 32'd0);

        // start+stop in IDLE runs; clear in the tick cycle suppresses the count
        cmd(1'b1, 1'b1, 1'b0, 1'b0);
        chk("startstop_idle", 32'(bus.o_running), 32'd1);
        cyc(3);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_tick_cycle_tick", 32'(bus.o_tick), 32'd0);
        chk("clr_tick_cycle_bcd", 32'(bus.o_bcd_out), 32'h00);
        chk("clr_tick_cycle_run", 32'(bus.o_running), 32'd0);

        // start+stop in RUN pauses
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2);
        cmd(1'b1, 1'b1, 1'b0, 1'b0);
        chk("startstop_run", 32'(bus.o_running), 32'd0);

        // 6: lap freeze
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        wait_bcd(8'h12, 300, "reach_12");
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        nt = 0;
        for (int i = 0; i < 100 && nt < 5; i++) begin
            cyc(1);
            if (bus.o_tick) nt++;
        end
        chk("lap_ticks", 32'(nt), 32'd5);
`ifdef LAP_HOLD_EN
        chk("lap_frozen", 32'(bus.o_bcd_out), 32'h12);
`else
        chk("lap_live", 32'(bus.o_bcd_out), 32'h17);
`endif
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_release", 32'(bus.o_bcd_out), 32'h17);

        // 7: reset mid-run wins over a start pulse
        bus.i_start = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.i_start = 1'b0;
        chk("midrst_running", 32'(bus.o_running), 32'd0);
        chk("midrst_bcd", 32'(bus.o_bcd_out), 32'h00);
        chk("midrst_tick", 32'(bus.o_tick), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
